button_debounce_ctrl: RTL and testbench

Multi-channel push-button debounce controller. It sequences one shared divided-clock tick generator across `N_BTN` raw button inputs and runs one debounce state machine per channel. Each channel produces a clean level and a single-cycle press pulse. It sits between the board's push-buttons and any logic that consumes button events, such as mode/step controls. Everything runs on the system clock, using the tick as an enable; no derived clocks are created.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/tick_gen.sv | 43 ++++
 rtl/button_debounce_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_button_debounce_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : debounce_pkg
//  Description : Shared types and default constants for the multi-channel
//                push-button debounce controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Per-channel debounce state; the two CHK states qualify a candidate change.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // Defaults: 1 ms sample tick at 1 GHz-class clocks down to 10 ms at 100 MHz.
  localparam int c_TICK_DIV_DEFAULT     = 1_000_000;
  localparam int c_STABLE_TICKS_DEFAULT = 4;
  localparam int c_REPEAT_TICKS_DEFAULT = 50;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running divider producing a registered one-clock sample
//                strobe every TICK_DIV system clocks. The strobe is high for
//                the clock following the counter reaching TICK_DIV-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = c_TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                 c_CNT_W = $clog2(TICK_DIV);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tick;

  // Divider counter 0..TICK_DIV-1 with a registered strobe on terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == c_LAST);
      if (r_cnt == c_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign tick = r_tick;

endmodule : tick_gen
`default_nettype wire

// File: rtl/button_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_ctrl
//  Description : N_BTN-channel push-button debouncer. Each raw input is
//                synchronised with two flops, then qualified by a per-channel
//                FSM that accepts a change only after STABLE_TICKS consecutive
//                sample ticks of the new value. Produces a clean level and a
//                single-clock press pulse per channel. All logic runs on clk,
//                with the shared tick used purely as an enable.
//  Options     : `define DEBOUNCE_AUTOREPEAT_EN to emit an extra press pulse
//                every REPEAT_TICKS ticks while a button stays pressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = c_TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = c_STABLE_TICKS_DEFAULT,
  parameter int REPEAT_TICKS = c_REPEAT_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             tick
);

  localparam int                 c_CNT_W       = $clog2(STABLE_TICKS + 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_TICKS - 1);

  // Reject illegal configurations at elaboration time.
  if (N_BTN < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_err
    $error("button_debounce_ctrl: illegal parameter value");
  end

  logic [N_BTN-1:0] r_sync_q1;
  logic [N_BTN-1:0] r_sync_q2;
  logic             w_tick;

  // Two-flop synchroniser on every raw button input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_q1 <= '0;
      r_sync_q2 <= '0;
    end else begin
      r_sync_q1 <= btn_in;
      r_sync_q2 <= r_sync_q1;
    end
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_pulse;
    logic               w_s;

    assign w_s = r_sync_q2[g];

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int                 c_REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_TICKS - 1);

    logic [c_REP_W-1:0] r_rep;

    // Debounce FSM with auto-repeat; bounce back to the old level beats a tick.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= RELEASED;
        r_cnt   <= '0;
        r_rep   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        case (r_state)
          RELEASED: begin
            if (w_s) begin
              r_state <= PRESS_CHK;
              r_cnt   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!w_s) begin
              r_state <= RELEASED;
            end else if (w_tick) begin
              if (r_cnt == c_STABLE_LAST) begin
                r_state <= PRESSED;
                r_level <= 1'b1;
                r_pulse <= 1'b1;
                r_rep   <= '0;
              end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
              end
            end
          end
          PRESSED: begin
            if (!w_s) begin
              r_state <= RELEASE_CHK;
              r_cnt   <= '0;
            end else if (w_tick) begin
              if (r_rep == c_REP_LAST) begin
                r_rep   <= '0;
                r_pulse <= 1'b1;
              end else begin
                r_rep <= r_rep + c_REP_W'(1);
              end
            end
          end
          RELEASE_CHK: begin
            if (w_s) begin
              r_state <= PRESSED;
              r_rep   <= '0;
            end else if (w_tick) begin
              if (r_cnt == c_STABLE_LAST) begin
                r_state <= RELEASED;
                r_level <= 1'b0;
              end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
              end
            end
          end
          default: r_state <= RELEASED;
        endcase
      end
    end
`else
    // Debounce FSM; bounce back to the old level beats a tick in the same cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= RELEASED;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        case (r_state)
          RELEASED: begin
            if (w_s) begin
              r_state <= PRESS_CHK;
              r_cnt   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!w_s) begin
              r_state <= RELEASED;
            end else if (w_tick) begin
              if (r_cnt == c_STABLE_LAST) begin
                r_state <= PRESSED;
                r_level <= 1'b1;
                r_pulse <= 1'b1;
              end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
              end
            end
          end
          PRESSED: begin
            if (!w_s) begin
              r_state <= RELEASE_CHK;
              r_cnt   <= '0;
            end
          end
          RELEASE_CHK: begin
            if (w_s) begin
              r_state <= PRESSED;
            end else if (w_tick) begin
              if (r_cnt == c_STABLE_LAST) begin
                r_state <= RELEASED;
                r_level <= 1'b0;
              end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
              end
            end
          end
          default: r_state <= RELEASED;
        endcase
      end
    end
`endif

    assign btn_level[g] = r_level;
    assign btn_pulse[g] = r_pulse;
  end

endmodule : button_debounce_ctrl
`default_nettype wire

// File: tb/tb_button_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce_ctrl
//  Description : Directed self-checking bench for button_debounce_ctrl with
//                TICK_DIV=4, STABLE_TICKS=3, REPEAT_TICKS=5. Every scenario
//                starts on the clock where tick has just risen, so a press
//                applied there is accepted on the 13th following clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  button_debounce_ctrl #(
    .N_BTN        (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .REPEAT_TICKS (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rise_step;
    int fall_step;
    int pulse_step;
    int n_pulse;
    logic [3:0] acc;
    logic level_dropped;
    int split;

    reset  = 1'b1;
    btn_in = 4'b0000;

    // Reset: outputs held at zero.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_pulse", 32'(btn_pulse), 32'h0);
      check("rst_tick",  32'(tick),      32'h0);
    end
    reset = 1'b0;

    // Tick on clocks 4, 8, 12 after release.
    for (int i = 1; i <= 12; i++) begin
      step();
      check("tick_phase", 32'(tick), (i % 4 == 0) ? 32'h1 : 32'h0);
    end

    // One-clock reset mid-stream restarts the tick phase.
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("midrst_phase", 32'(tick), (i == 4) ? 32'h1 : 32'h0);
    end

    // Clean press on channel 0, held 40 clocks.
    btn_in[0] = 1'b1;
    rise_step = 0; pulse_step = 0; n_pulse = 0; acc = '0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (btn_pulse[0]) begin
        n_pulse++;
        if (pulse_step == 0) pulse_step = i;
      end
      if (btn_level[0] && rise_step == 0) rise_step = i;
      acc = acc | {btn_level[3:1] | btn_pulse[3:1], 1'b0};
    end
    check("press_rise", 32'(rise_step), 32'd13);
    check("press_pulse_at", 32'(pulse_step), 32'd13);
    check("press_others", 32'(acc), 32'h0);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    check("press_npulse", 32'(n_pulse), 32'd2);
`else
    check("press_npulse", 32'(n_pulse), 32'd1);
`endif

    // Release bounce: low for 6 clocks then high again.
    btn_in[0] = 1'b0;
    level_dropped = 1'b0; n_pulse = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 7) btn_in[0] = 1'b1;
      step();
      if (!btn_level[0]) level_dropped = 1'b1;
      if (btn_pulse[0]) n_pulse++;
    end
    check("relbounce_level", 32'(level_dropped), 32'h0);
    check("relbounce_pulse", 32'(n_pulse), 32'd0);

    // Real release: low for 20 clocks.
    btn_in[0] = 1'b0;
    fall_step = 0; n_pulse = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!btn_level[0] && fall_step == 0) fall_step = i;
      if (btn_pulse[0]) n_pulse++;
    end
    check("release_fall", 32'(fall_step), 32'd13);
    check("release_pulse", 32'(n_pulse), 32'd0);

    // Bounce reject on channel 1: toggle every 5 clocks for 60 clocks.
    acc = '0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) btn_in[1] = ~btn_in[1];
      step();
      acc = acc | (btn_level & 4'b0010) | (btn_pulse & 4'b0010);
    end
    btn_in[1] = 1'b0;
    check("bounce_ch1", 32'(acc), 32'h0);
    check("bounce_ch0_idle", 32'(btn_level), 32'h0);

    // Simultaneous press on channels 2 and 3.
    btn_in[3:2] = 2'b11;
    pulse_step = 0; split = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (btn_pulse == 4'b1100 && pulse_step == 0) pulse_step = i;
      if (btn_pulse[2] != btn_pulse[3]) split++;
    end
    check("simul_pulse_at", 32'(pulse_step), 32'd13);
    check("simul_split", 32'(split), 32'd0);
    check("simul_level", 32'(btn_level), 32'hC);
    btn_in[3:2] = 2'b00;
    for (int i = 1; i <= 20; i++) step();
    check("simul_release", 32'(btn_level), 32'h0);

    // Reset while channel 2 is qualifying a press.
    btn_in[2] = 1'b1;
    acc = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      acc = acc | btn_level | btn_pulse;
    end
    check("abort_pre", 32'(acc), 32'h0);
    reset = 1'b1;
    btn_in[2] = 1'b0;
    step();
    check("abort_rst_level", 32'(btn_level), 32'h0);
    check("abort_rst_pulse", 32'(btn_pulse), 32'h0);
    reset = 1'b0;
    acc = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      acc = acc | btn_level | btn_pulse;
    end
    check("abort_post", 32'(acc), 32'h0);
    check("abort_tick_phase", 32'(tick), 32'h1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Auto-repeat: hold 100 clocks -> pulses at 13, 33, 53, 73, 93.
    btn_in[0] = 1'b1;
    n_pulse = 0; split = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (btn_pulse[0]) n_pulse++;
      if (btn_pulse[0] != (i >= 13 && (i - 13) % 20 == 0)) split++;
    end
    check("rep_count", 32'(n_pulse), 32'd5);
    check("rep_position", 32'(split), 32'd0);
    btn_in[0] = 1'b0;
    n_pulse = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (btn_pulse[0]) n_pulse++;
    end
    check("rep_stop", 32'(n_pulse), 32'd0);
    check("rep_level", 32'(btn_level), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_debounce_ctrl
`default_nettype wire
